// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: pipelined IM requests feed a DEPTH-entry
// prefetch queue toward ID, with redirect flush and stale-response drop.
module if_prefetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int                    DEPTH        = 4
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         STALL,
  input  logic [ADDR_WIDTH-1:0]        AltPC_IN,
  input  logic                         AltPCEnable_IN,
  input  logic [ADDR_WIDTH-1:0]        JumpReg_IN,
  input  logic                         JumpRegEnable_IN,
  output logic                         IM_Req_OUT,
  output logic [ADDR_WIDTH-1:0]        IM_Addr_OUT,
  input  logic                         IM_Gnt_IN,
  input  logic                         IM_RValid_IN,
  input  logic [31:0]                  IM_RData_IN,
  output logic                         ID_Valid_OUT,
  output logic [31:0]                  ID_Instr_OUT,
  output logic [ADDR_WIDTH-1:0]        ID_PC_OUT,
  output logic [ADDR_WIDTH-1:0]        ID_PCPlus4_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy_OUT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0]           L_DEPTH = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] L_FOUR  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] L_ALIGN = ~ADDR_WIDTH'(3);

  logic [31:0]           r_q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc    [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         r_drop;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [CW:0]           w_credit_sum;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_rsp;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop_hit;

  assign w_redirect   = JumpRegEnable_IN | AltPCEnable_IN;
  assign w_target     = (JumpRegEnable_IN ? JumpReg_IN : AltPC_IN) & L_ALIGN;
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req        = !RESET && !w_redirect && (w_credit_sum < L_DEPTH);
  assign w_grant      = w_req && IM_Gnt_IN;
  // Responses with nothing outstanding are spurious and ignored
  assign w_rsp        = IM_RValid_IN && (r_inflight != '0);
  assign w_drop_hit   = w_rsp && (r_drop != '0);
  assign w_push       = w_rsp && (r_drop == '0) && !w_redirect;
  assign w_pop        = (r_count != '0) && !STALL;

  assign IM_Req_OUT     = w_req;
  assign IM_Addr_OUT    = r_fetch_pc;
  assign ID_Valid_OUT   = (r_count != '0);
  assign ID_Instr_OUT   = (r_count != '0) ? r_q_instr[r_head] : 32'h0;
  assign ID_PC_OUT      = r_q_pc[r_head];
  assign ID_PCPlus4_OUT = r_q_pc[r_head] + L_FOUR;
  assign Occupancy_OUT  = r_count;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_fetch_pc <= RESET_VECTOR;
      r_resp_pc  <= RESET_VECTOR;
    end else begin
      r_inflight <= r_inflight + CW'(w_grant) - CW'(w_rsp);
      if (w_redirect) begin
        // Everything still outstanding belongs to the old path
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_drop     <= r_inflight - CW'(w_rsp);
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + L_FOUR;
        end
        if (w_drop_hit) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push) begin
          r_q_instr[r_tail] <= IM_RData_IN;
          r_q_pc[r_tail]    <= r_resp_pc;
          r_tail            <= r_tail + PW'(1);
          r_resp_pc         <= r_resp_pc + L_FOUR;
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios plus random traffic
// against a request/response queue model of the fetch stream.
module tb_if_prefetch_unit;

  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int rdy; } mem_t;

  logic        clk = 1'b0;
  logic        rst, stall, alt_en, jr_en, gnt, rvalid;
  logic [31:0] alt_pc, jr_pc, rdata;
  bit          sel, inj, nochk;
  int          fixlat;

  logic        req32, val32, req16, val16;
  logic [31:0] addr32, ins32, pc32, pc4_32, ins16;
  logic [15:0] addr16, pc16, pc4_16;
  logic [2:0]  occ32, occ16;

  logic        w_req, w_val;
  logic [31:0] w_addr, w_ins, w_pc, w_pc4;
  logic [2:0]  w_occ;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_fetch;
  out_t        outs[$];
  ent_t        fifo[$];
  mem_t        mem[$];

  bit          want_en;
  logic [31:0] want_pc;
  string       want_tag;

  always #5 clk = ~clk;

  if_prefetch_unit u_dut32 (
    .CLOCK(clk), .RESET(rst), .STALL(stall),
    .AltPC_IN(alt_pc), .AltPCEnable_IN(alt_en),
    .JumpReg_IN(jr_pc), .JumpRegEnable_IN(jr_en),
    .IM_Req_OUT(req32), .IM_Addr_OUT(addr32), .IM_Gnt_IN(gnt),
    .IM_RValid_IN(rvalid && !sel), .IM_RData_IN(rdata),
    .ID_Valid_OUT(val32), .ID_Instr_OUT(ins32), .ID_PC_OUT(pc32),
    .ID_PCPlus4_OUT(pc4_32), .Occupancy_OUT(occ32)
  );

  if_prefetch_unit #(
    .ADDR_WIDTH(16), .RESET_VECTOR(16'hFFF8), .DEPTH(4)
  ) u_dut16 (
    .CLOCK(clk), .RESET(rst), .STALL(stall),
    .AltPC_IN(alt_pc[15:0]), .AltPCEnable_IN(alt_en),
    .JumpReg_IN(jr_pc[15:0]), .JumpRegEnable_IN(jr_en),
    .IM_Req_OUT(req16), .IM_Addr_OUT(addr16), .IM_Gnt_IN(gnt),
    .IM_RValid_IN(rvalid && sel), .IM_RData_IN(rdata),
    .ID_Valid_OUT(val16), .ID_Instr_OUT(ins16), .ID_PC_OUT(pc16),
    .ID_PCPlus4_OUT(pc4_16), .Occupancy_OUT(occ16)
  );

  assign w_req  = sel ? req16 : req32;
  assign w_val  = sel ? val16 : val32;
  assign w_addr = sel ? {16'h0, addr16} : addr32;
  assign w_ins  = sel ? ins16 : ins32;
  assign w_pc   = sel ? {16'h0, pc16} : pc32;
  assign w_pc4  = sel ? {16'h0, pc4_16} : pc4_32;
  assign w_occ  = sel ? occ16 : occ32;

  function automatic logic [31:0] amask();
    return sel ? 32'h0000FFFF : 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit          redir, mreq;
    logic [31:0] tgt;
    out_t        o;
    int          r;
    rvalid = 1'b0;
    rdata  = '0;
    if (inj) begin
      rvalid = 1'b1;
      rdata  = 32'hDEADBEEF;
    end else if (mem.size() != 0 && mem[0].rdy <= cyc) begin
      rvalid = 1'b1;
      rdata  = ifn(mem[0].addr);
    end
    @(negedge clk);
    redir = alt_en || jr_en;
    tgt   = (jr_en ? jr_pc : alt_pc) & amask() & 32'hFFFFFFFC;
    mreq  = !rst && !redir && (fifo.size() + outs.size() < 4);
    if (!nochk) begin
      chk("req", 32'(w_req), 32'(mreq));
      chk("addr", w_addr, m_fetch);
      chk("valid", 32'(w_val), 32'(fifo.size() != 0));
      chk("occ", 32'(w_occ), 32'(fifo.size()));
      if (fifo.size() != 0) begin
        chk("pc", w_pc, fifo[0].pc);
        chk("pc4", w_pc4, (fifo[0].pc + 32'd4) & amask());
        chk("instr", w_ins, fifo[0].instr);
      end else begin
        chk("instr_idle", w_ins, 32'h0);
      end
      if (want_en && w_val && !stall) begin
        chk(want_tag, w_pc, want_pc);
        want_en = 1'b0;
      end
    end
    if (rst) begin
      m_fetch = sel ? 32'h0000FFF8 : 32'hBFC00000;
      outs.delete();
      fifo.delete();
      mem.delete();
    end else begin
      if (fifo.size() != 0 && !stall) void'(fifo.pop_front());
      if (rvalid && outs.size() != 0) begin
        o = outs.pop_front();
        if (!o.stale && !redir) fifo.push_back('{rdata, o.addr});
      end
      if (rvalid && !inj) void'(mem.pop_front());
      if (redir) begin
        fifo.delete();
        foreach (outs[i]) outs[i].stale = 1'b1;
        m_fetch = tgt;
      end else if (mreq && gnt) begin
        outs.push_back('{m_fetch, 1'b0});
        r = cyc + ((fixlat != 0) ? fixlat : int'($urandom_range(1, 4)));
        if (mem.size() != 0 && r <= mem[$].rdy) r = mem[$].rdy + 1;
        mem.push_back('{m_fetch, r});
        m_fetch = (m_fetch + 32'd4) & amask();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_next(input string tag, input logic [31:0] pc);
    want_en  = 1'b1;
    want_pc  = pc;
    want_tag = tag;
    for (int i = 0; i < 40 && want_en; i++) step();
    chk({tag, "_seen"}, 32'(want_en), 32'd0);
    want_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    sel = 0; inj = 0; nochk = 0; want_en = 0; fixlat = 1;
    rst = 1; stall = 0; alt_en = 0; jr_en = 0; gnt = 0;
    alt_pc = '0; jr_pc = '0; rvalid = 0; rdata = '0;
    m_fetch = 32'hBFC00000;
    @(posedge clk);
    #1;
    nochk = 1;
    step();
    nochk = 0;
    step();
    chk("rst_req", 32'(w_req), 32'd0);
    chk("rst_valid", 32'(w_val), 32'd0);
    chk("rst_occ", 32'(w_occ), 32'd0);
    chk("rst_instr", w_ins, 32'h0);
    chk("rst_addr", w_addr, 32'hBFC00000);

    // straight-line fetch
    rst = 0; gnt = 1;
    expect_next("t1_pc0", 32'hBFC00000);
    expect_next("t1_pc1", 32'hBFC00004);
    expect_next("t1_pc2", 32'hBFC00008);

    // back-pressure
    stall = 1;
    repeat (10) step();
    chk("t2_occ", 32'(w_occ), 32'd4);
    chk("t2_req", 32'(w_req), 32'd0);
    stall = 0;
    repeat (8) step();

    // branch with responses in flight
    fixlat = 2;
    repeat (8) step();
    alt_en = 1; alt_pc = 32'hBFC00100;
    step();
    alt_en = 0;
    expect_next("t3_target", 32'hBFC00100);

    // jump-register wins over branch
    repeat (5) step();
    jr_en = 1; jr_pc = 32'hBFC00200;
    alt_en = 1; alt_pc = 32'hBFC00300;
    step();
    jr_en = 0; alt_en = 0;
    chk("t4_addr", w_addr, 32'hBFC00200);
    expect_next("t4_target", 32'hBFC00200);

    // reset mid-stream, then a late response
    stall = 1;
    repeat (6) step();
    rst = 1;
    step();
    rst = 0;
    chk("t5_valid", 32'(w_val), 32'd0);
    chk("t5_occ", 32'(w_occ), 32'd0);
    chk("t5_instr", w_ins, 32'h0);
    chk("t5_addr", w_addr, 32'hBFC00000);
    inj = 1;
    step();
    inj = 0; stall = 0;
    expect_next("t5_restart", 32'hBFC00000);

    // 16-bit instance: wrap and alignment
    sel = 1; fixlat = 1; rst = 1;
    nochk = 1;
    step();
    nochk = 0;
    rst = 0;
    expect_next("t6_pc0", 32'h0000FFF8);
    expect_next("t6_pc1", 32'h0000FFFC);
    expect_next("t6_wrap", 32'h00000000);
    alt_en = 1; alt_pc = 32'h00000102;
    step();
    alt_en = 0;
    expect_next("t6_alt", 32'h00000100);

    // random traffic on both widths
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1); rst = 1; fixlat = 0;
      alt_en = 0; jr_en = 0;
      nochk = 1;
      step();
      nochk = 0;
      step();
      rst = 0;
      for (int i = 0; i < 900; i++) begin
        int r;
        stall = ($urandom_range(0, 9) < 3);
        gnt   = ($urandom_range(0, 9) < 7);
        r     = int'($urandom_range(0, 99));
        alt_en = (r < 4);
        jr_en  = (r >= 2 && r < 6);
        alt_pc = sel ? 32'($urandom_range(0, 65535))
                     : (32'hBFC00000 | 32'($urandom_range(0, 4095)));
        jr_pc  = sel ? 32'($urandom_range(0, 65535))
                     : (32'hBFC00000 | 32'($urandom_range(0, 4095)));
        rst    = ($urandom_range(0, 199) == 0);
        step();
      end
      rst = 0; alt_en = 0; jr_en = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
